uart_tx_fifo: RTL and testbench

Self-timed UART transmitter, 8N1, clocked directly from the 12 MHz system clock. It generates its own bit timing, so no separate baud clock is needed. Bytes arrive over a valid/ready handshake into an internal FIFO and are serialized back-to-back onto the TX pin. It is the transmit-side counterpart to the existing system-clock receiver, letting the top level echo or stream data without driving `i_tx_start` by hand.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the system-clock transmitter and receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam int   STOP_BITS  = 1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Rounded to the nearest cycle so non-integer ratios keep the smallest bit-time error.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come from the occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      o_full   = (count_q == FULL_CNT);
      o_empty  = (count_q == '0);
      do_push  = i_push && !o_full;
      do_pop   = i_pop && !o_empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_ONE;
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_count = count_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge i_clk) begin
      if (do_push && !i_rst) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with input FIFO, bit timing derived from the system clock.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit time
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); pops the next byte at its end for gapless frames
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 12000000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [7:0]                  i_data,
   input  logic                        i_valid,
   output logic                        o_ready,
   output logic                        o_tx,
   output logic                        o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_count
);

   if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
   end
   if (STOP_BITS != 1) begin : g_stop_check
      $error("uart_tx_fifo: only one stop bit is implemented");
   end

   localparam int            BW          = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
   localparam logic [2:0]    BIT_LAST    = 3'(DATA_BITS - 1);

   tx_state_t              state_q, state_d;
   logic [BW-1:0]          baud_cnt_q, baud_cnt_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   out_en_q, out_en_d;
   logic                   baud_done;

   logic                   fifo_push, fifo_pop;
   logic                   fifo_full, fifo_empty;
   logic [DATA_BITS-1:0]   fifo_data;

   // Ready follows the registered count only, so a pop never frees a slot in the same cycle.
   assign o_ready   = out_en_q && !fifo_full;
   assign fifo_push = i_valid && o_ready;
   assign o_tx      = tx_q;
   assign o_busy    = busy_q;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (fifo_push),
      .i_data  (i_data),
      .i_pop   (fifo_pop),
      .o_data  (fifo_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (o_count)
   );

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      out_en_d   = 1'b1;
      fifo_pop   = 1'b0;
      baud_done  = (baud_cnt_q == '0);

      if (state_q != IDLE && !baud_done) begin
         baud_cnt_d = baud_cnt_q - BAUD_ONE;
      end

      unique case (state_q)
         IDLE: begin
            tx_d   = IDLE_LEVEL;
            busy_d = 1'b0;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_d    = fifo_data;
               baud_cnt_d = BAUD_RELOAD;
               state_d    = START;
               tx_d       = ~IDLE_LEVEL;
               busy_d     = 1'b1;
            end
         end
         START: begin
            if (baud_done) begin
               state_d    = DATA;
               bit_idx_d  = '0;
               baud_cnt_d = BAUD_RELOAD;
               tx_d       = shift_q[0];
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_cnt_d = BAUD_RELOAD;
               if (bit_idx_q == BIT_LAST) begin
                  state_d = STOP;
                  tx_d    = IDLE_LEVEL;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
         STOP: begin
            if (baud_done) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shift_d    = fifo_data;
                  baud_cnt_d = BAUD_RELOAD;
                  state_d    = START;
                  tx_d       = ~IDLE_LEVEL;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  tx_d    = IDLE_LEVEL;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= IDLE_LEVEL;
         busy_q     <= 1'b0;
         out_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         out_en_q   <= out_en_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at 4 clocks per bit: directed stimulus, line decoded by a scoreboard monitor.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;
   logic [4:0] count;

   int         errors = 0;
   int         checks = 0;
   int         frames = 0;
   bit         mon_en = 1'b0;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(
      .CLK_FREQ   (40),
      .BAUD       (10),
      .FIFO_DEPTH (16)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (data),
      .i_valid (valid),
      .o_ready (ready),
      .o_tx    (tx),
      .o_busy  (busy),
      .o_count (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds valid until the byte is taken; the accepted byte goes into the scoreboard.
   task automatic push_byte(input logic [7:0] b, output int waited);
      data   = b;
      valid  = 1'b1;
      waited = 0;
      while (ready !== 1'b1 && waited < 200) begin
         step();
         waited++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: byte %02h not accepted within %0d cycles", b, waited);
      end else begin
         step();
         exp_q.push_back(b);
      end
      valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
         step();
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   // Monitor: detects a start bit, samples mid-bit, compares against the scoreboard.
   initial begin : monitor
      logic [7:0] rx;
      logic       stop_b;
      logic [7:0] e;
      bit         abort;
      rx     = '0;
      stop_b = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && tx === 1'b0) begin
            abort = 1'b0;
            for (int k = 1; k <= 9; k++) begin
               for (int j = 0; j < 4; j++) begin
                  @(negedge clk);
                  if (rst) abort = 1'b1;
               end
               if (k <= 8) rx[k-1] = tx;
               else stop_b = tx;
            end
            if (!abort) begin
               frames++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got byte %02h, none expected", rx);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_byte", rx, e);
                  chk("stop_bit", stop_b, 1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int         w;
      int         bad;
      int         busy_cnt;
      int         wsum;
      logic [9:0] pat;

      // Reset state
      rst = 1'b1;
      repeat (3) step();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", ready, 0);
      rst = 1'b0;
      step();
      chk("ready_after_release", ready, 1);
      mon_en = 1'b1;

      // Idle stability
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
      end
      chk("idle_stable", bad, 0);

      // Single byte 0x55: line reads 0,1,0,1,... every 4 cycles from N+1
      push_byte(8'h55, w);
      chk("t1_count_after_push", count, 1);
      chk("t1_tx_before_start", tx, 1);
      pat      = 10'b1010101010;
      busy_cnt = 0;
      for (int c = 1; c <= 48; c++) begin
         step();
         if (busy === 1'b1) busy_cnt++;
         if (c == 1) chk("t1_count_after_pop", count, 0);
         if ((c - 1) % 4 == 0 && c <= 37) chk("t1_line_bit", tx, pat[(c-1)/4]);
         if (c == 40) chk("t1_busy_last", busy, 1);
         if (c == 41) begin
            chk("t1_busy_end", busy, 0);
            chk("t1_tx_end", tx, 1);
         end
      end
      chk("t1_busy_cycles", busy_cnt, 40);
      wait_drain("t1_drain");

      // Back-to-back 0x41, 0x42
      push_byte(8'h41, w);
      push_byte(8'h42, w);
      chk("t2_start_tx", tx, 0);
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      for (int c = 2; c <= 90; c++) begin
         step();
         if (busy === 1'b1) busy_cnt++;
         if (c == 40) chk("t2_stop1_tx", tx, 1);
         if (c == 41) begin
            chk("t2_start2_tx", tx, 0);
            chk("t2_start2_busy", busy, 1);
         end
         if (c == 80) chk("t2_busy_last", busy, 1);
         if (c == 81) chk("t2_busy_end", busy, 0);
      end
      chk("t2_busy_cycles", busy_cnt, 80);
      wait_drain("t2_drain");

      // Full FIFO with 20 distinct bytes
      wsum = 0;
      for (int i = 0; i < 17; i++) begin
         push_byte(8'h10 + 8'(i), w);
         wsum += w;
      end
      chk("t3_first17_no_wait", wsum, 0);
      chk("t3_full_count", count, 16);
      chk("t3_full_ready", ready, 0);
      push_byte(8'h21, w);
      chk("t3_wait_first_pop", w, 25);
      chk("t3_refill_count", count, 16);
      chk("t3_refill_ready", ready, 0);
      push_byte(8'h22, w);
      chk("t3_wait_second_pop", w, 39);
      push_byte(8'h23, w);
      chk("t3_wait_third_pop", w, 39);
      wait_drain("t3_drain");

      // Reset during DATA bit 3 with 3 bytes queued
      push_byte(8'hA1, w);
      push_byte(8'hB2, w);
      push_byte(8'hC3, w);
      push_byte(8'hD4, w);
      chk("t4_queued", count, 3);
      repeat (15) step();
      chk("t4_busy_before_rst", busy, 1);
      rst = 1'b1;
      exp_q.delete();
      step();
      chk("t4_rst_tx", tx, 1);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_count", count, 0);
      chk("t4_rst_ready", ready, 0);
      rst = 1'b0;
      step();
      chk("t4_ready_release", ready, 1);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0) bad++;
      end
      chk("t4_line_idle", bad, 0);

      // Push coinciding with the STOP-end pop while 2 bytes are queued
      push_byte(8'h3C, w);
      push_byte(8'hC3, w);
      push_byte(8'h5A, w);
      chk("t5_queued", count, 2);
      repeat (38) step();
      chk("t5_pre_count", count, 2);
      chk("t5_pre_stop_tx", tx, 1);
      push_byte(8'h99, w);
      chk("t5_push_no_wait", w, 0);
      chk("t5_count_held", count, 2);
      chk("t5_next_start", tx, 0);
      chk("t5_busy", busy, 1);
      wait_drain("t5_drain");

      chk("frame_total", frames, 27);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
